// File: rtl/mem_stage.sv
// mem_stage: memory/writeback stage downstream of the ALU.
// Registers ALU results, runs LD/ST against data memory over a req/ack
// handshake, owns the architectural {N,Z} flag register and issues one
// writeback per instruction.
// Optional feature: define MEM_TIMEOUT_EN to bound the ack wait to TIMEOUT
// cycles. A timeout completes the instruction without a register write and
// sets the sticky mem_err flag.
module mem_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [1:0]        ex_flags,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        flag_reg,
    output logic              mem_err
);

    localparam logic [4:0] OP_LD  = 5'b11101;
    localparam logic [4:0] OP_ST  = 5'b11100;
    localparam logic [4:0] OP_CMP = 5'b10010;

    typedef enum logic {IDLE, MEM} state_t;

    state_t            state, state_d;
    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [4:0]        mem_rd, mem_rd_d;
    logic              wb_valid_d, wb_we_d;
    logic [4:0]        wb_rd_d;
    logic [DATA_W-1:0] wb_data_d;
    logic [1:0]        flag_d;
    logic              accept;
    logic              is_mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_q, err_d;
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign ex_ready  = (state == IDLE);
    assign accept    = ex_valid & ex_ready & ~flush;
    assign is_mem_op = (ex_opcode == OP_LD) || (ex_opcode == OP_ST);

    // Next-state and next-output decode; defaults hold state, drop the pulse
    always_comb begin
        state_d    = state;
        req_d      = dmem_req;
        we_d       = dmem_we;
        addr_d     = dmem_addr;
        wdata_d    = dmem_wdata;
        mem_rd_d   = mem_rd;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd;
        wb_data_d  = wb_data;
        flag_d     = flag_reg;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt;
        err_d      = err_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem_op) begin
                        state_d  = MEM;
                        req_d    = 1'b1;
                        we_d     = (ex_opcode == OP_ST);
                        addr_d   = ex_alu_out[ADDR_W-1:0];
                        wdata_d  = ex_st_data;
                        mem_rd_d = ex_rd;
`ifdef MEM_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_alu_out;
                        wb_we_d    = (ex_opcode != OP_CMP) && (ex_rd != 5'd0);
                        if (ex_opcode == OP_CMP) begin
                            flag_d = ex_flags;
                        end
                    end
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = mem_rd;
                    if (dmem_we) begin
                        wb_we_d   = 1'b0;
                        wb_data_d = '0;
                    end else begin
                        wb_we_d   = (mem_rd != 5'd0);
                        wb_data_d = dmem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = mem_rd;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_rd     <= 5'd0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            flag_reg   <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            cnt        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_wdata <= wdata_d;
            mem_rd     <= mem_rd_d;
            wb_valid   <= wb_valid_d;
            wb_we      <= wb_we_d;
            wb_rd      <= wb_rd_d;
            wb_data    <= wb_data_d;
            flag_reg   <= flag_d;
`ifdef MEM_TIMEOUT_EN
            cnt        <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU writeback, CMP flags, LD/ST
// handshake, flush, reset during an access, optional ack timeout.
module tb_mem_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_LD  = 5'b11101;
    localparam logic [4:0] OP_ST  = 5'b11100;
    localparam logic [4:0] OP_CMP = 5'b10010;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic [4:0]        ex_opcode;
    logic [DATA_W-1:0] ex_alu_out;
    logic [1:0]        ex_flags;
    logic [DATA_W-1:0] ex_st_data;
    logic [4:0]        ex_rd;
    logic              flush;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        flag_reg;
    logic              mem_err;

    int n_vec  = 0;
    int n_miss = 0;

    mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_alu_out(ex_alu_out), .ex_flags(ex_flags), .ex_st_data(ex_st_data),
        .ex_rd(ex_rd), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flag_reg(flag_reg), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] alu,
                         input logic [1:0] fl, input logic [31:0] sd, input logic [4:0] rd);
        ex_valid   = 1'b1;
        ex_opcode  = op;
        ex_alu_out = alu;
        ex_flags   = fl;
        ex_st_data = sd;
        ex_rd      = rd;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_alu_out = '0; ex_flags = '0;
        ex_st_data = '0; ex_rd = '0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        step(); step();

        // Reset state
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_flag", 64'(flag_reg), 64'd0);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        rst = 1'b0;
        step();

        // ADD
        issue(OP_ADD, 32'h0000_0005, 2'b00, 32'h0, 5'd3);
        step();
        chk("add_wb_valid", 64'(wb_valid), 64'd1);
        chk("add_wb_we", 64'(wb_we), 64'd1);
        chk("add_wb_rd", 64'(wb_rd), 64'd3);
        chk("add_wb_data", 64'(wb_data), 64'd5);
        chk("add_ready", 64'(ex_ready), 64'd1);

        // CMP sets flags, following ADD leaves them
        issue(OP_CMP, 32'h0000_0009, 2'b01, 32'h0, 5'd7);
        step();
        chk("cmp_flag", 64'(flag_reg), 64'd1);
        chk("cmp_wb_valid", 64'(wb_valid), 64'd1);
        chk("cmp_wb_we", 64'(wb_we), 64'd0);
        issue(OP_ADD, 32'h0000_0011, 2'b10, 32'h0, 5'd2);
        step();
        chk("add2_flag", 64'(flag_reg), 64'd1);
        chk("add2_wb_data", 64'(wb_data), 64'h11);
        ex_valid = 1'b0;
        step();
        chk("idle_wb_valid", 64'(wb_valid), 64'd0);
        chk("idle_wb_data_hold", 64'(wb_data), 64'h11);

        // LD with ack on the third request cycle
        issue(OP_LD, 32'h0000_0010, 2'b00, 32'h0, 5'd4);
        step();
        ex_valid = 1'b0;
        chk("ld_wb_valid0", 64'(wb_valid), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("ld_req", 64'(dmem_req), 64'd1);
            chk("ld_we", 64'(dmem_we), 64'd0);
            chk("ld_addr", 64'(dmem_addr), 64'h0010);
            chk("ld_ready", 64'(ex_ready), 64'd0);
            if (c == 2) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        dmem_ack = 1'b0; dmem_rdata = '0;
        chk("ld_req_drop", 64'(dmem_req), 64'd0);
        chk("ld_wb_valid", 64'(wb_valid), 64'd1);
        chk("ld_wb_we", 64'(wb_we), 64'd1);
        chk("ld_wb_rd", 64'(wb_rd), 64'd4);
        chk("ld_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
        chk("ld_ready_back", 64'(ex_ready), 64'd1);

        // ST with same-cycle ack, then back-to-back ADD
        issue(OP_ST, 32'h0000_0020, 2'b00, 32'h1234_5678, 5'd9);
        step();
        ex_valid = 1'b0;
        chk("st_req", 64'(dmem_req), 64'd1);
        chk("st_we", 64'(dmem_we), 64'd1);
        chk("st_addr", 64'(dmem_addr), 64'h0020);
        chk("st_wdata", 64'(dmem_wdata), 64'h1234_5678);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("st_req_drop", 64'(dmem_req), 64'd0);
        chk("st_wb_valid", 64'(wb_valid), 64'd1);
        chk("st_wb_we", 64'(wb_we), 64'd0);
        chk("st_wb_data", 64'(wb_data), 64'd0);
        chk("st_ready", 64'(ex_ready), 64'd1);
        issue(OP_ADD, 32'h0000_0033, 2'b00, 32'h0, 5'd5);
        step();
        chk("b2b_wb_valid", 64'(wb_valid), 64'd1);
        chk("b2b_wb_rd", 64'(wb_rd), 64'd5);
        chk("b2b_wb_data", 64'(wb_data), 64'h33);

        // ADD to r0, then a flushed CMP
        issue(OP_ADD, 32'h0000_0044, 2'b00, 32'h0, 5'd0);
        step();
        chk("r0_wb_valid", 64'(wb_valid), 64'd1);
        chk("r0_wb_we", 64'(wb_we), 64'd0);
        issue(OP_CMP, 32'h0, 2'b10, 32'h0, 5'd1);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        chk("flush_wb_valid", 64'(wb_valid), 64'd0);
        chk("flush_flag", 64'(flag_reg), 64'd1);

        // Ack while idle is ignored
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_wb_valid", 64'(wb_valid), 64'd0);
        chk("idle_ack_req", 64'(dmem_req), 64'd0);

        // Reset in the middle of an access
        issue(OP_LD, 32'h0000_0030, 2'b00, 32'h0, 5'd6);
        step();
        ex_valid = 1'b0;
        chk("mid_req", 64'(dmem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 64'(dmem_req), 64'd0);
        chk("mid_rst_ready", 64'(ex_ready), 64'd1);
        chk("mid_rst_flag", 64'(flag_reg), 64'd0);
        step();
        rst = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("late_ack_wb_valid", 64'(wb_valid), 64'd0);
        chk("late_ack_req", 64'(dmem_req), 64'd0);

`ifdef MEM_TIMEOUT_EN
        // LD never acked times out after 4 request cycles
        issue(OP_LD, 32'h0000_0040, 2'b00, 32'h0, 5'd8);
        step();
        ex_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("to_req", 64'(dmem_req), 64'd1);
            step();
        end
        chk("to_req_drop", 64'(dmem_req), 64'd0);
        chk("to_wb_valid", 64'(wb_valid), 64'd1);
        chk("to_wb_we", 64'(wb_we), 64'd0);
        chk("to_err", 64'(mem_err), 64'd1);
        step();
        chk("to_err_sticky", 64'(mem_err), 64'd1);
`else
        chk("no_err", 64'(mem_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
